// File: rtl/direction_button_debouncer.sv
// Push-button front end: 2-flop synchroniser plus debounce FSM that toggles the
// counter direction (sel) once per accepted press.
module direction_button_debouncer #(
  parameter int unsigned DEBOUNCE_CNT = 999999,
  parameter int unsigned CNT_W        = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_in,
  output logic sel,
  output logic press_pulse,
  output logic btn_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CNT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_s1, r_s2;
  logic             r_sel, w_sel_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             r_level, w_level_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  // A level mismatch is tested before the terminal count so an abort always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_pulse_nxt = 1'b0;
    w_level_nxt = r_level;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_s2) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
          w_sel_nxt   = ~r_sel;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        w_cnt_nxt = '0;
        if (!r_s2) w_state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (r_s2) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sel         = r_sel;
  assign press_pulse = r_pulse;
  assign btn_level   = r_level;

endmodule

// File: tb/tb_direction_button_debouncer.sv
// Scoreboard bench for direction_button_debouncer (DEBOUNCE_CNT=3): stimulus pushes
// expected pulse / release events, a negedge monitor pops and checks them.
module tb_direction_button_debouncer;

  localparam int LAT     = 7;  // edge 1 samples the new level, event lands on edge 3+4
  localparam int K_PULSE = 0;
  localparam int K_FALL  = 1;

  typedef struct {
    int   kind;
    int   cyc;
    logic sel;
    logic lvl;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic btn_in;
  logic sel, press_pulse, btn_level;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic prev_level = 1'b0;

  direction_button_debouncer #(
    .DEBOUNCE_CNT(3),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_in     (btn_in),
    .sel        (sel),
    .press_pulse(press_pulse),
    .btn_level  (btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int at, input logic s, input logic l);
    exp_t e;
    e.kind = kind; e.cyc = at; e.sel = s; e.lvl = l;
    q.push_back(e);
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: {sel,pulse,level} got %b want %b at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse or falling debounced level must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1) begin
      if (press_pulse === 1'b1 || (prev_level === 1'b1 && btn_level === 1'b0)) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: pulse=%b level=%b sel=%b at cycle %0d, nothing expected",
                   press_pulse, btn_level, sel, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != (press_pulse === 1'b1 ? K_PULSE : K_FALL) || e.cyc != cyc ||
              sel !== e.sel || btn_level !== e.lvl) begin
            n_bad++;
            $display("FAIL event: got pulse=%b sel=%b level=%b at cycle %0d; want kind=%0d sel=%b level=%b at cycle %0d",
                     press_pulse, sel, btn_level, cyc, e.kind, e.sel, e.lvl, e.cyc);
          end
        end
      end else if (prev_level === 1'b0 && btn_level === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL level_rise: btn_level rose without pulse at cycle %0d", cyc);
      end
      if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: event kind=%0d due at cycle %0d not seen by cycle %0d", e.kind, e.cyc, cyc);
      end
    end
    prev_level = btn_level;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    btn_in = 1'b1;

    // Reset holds everything low even with the button pressed
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check3("reset_hold", {sel, press_pulse, btn_level}, 3'b000);
    end
    btn_in = 1'b0;
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(4);
    check3("idle_after_reset", {sel, press_pulse, btn_level}, 3'b000);

    // Clean press, held for 100 cycles: one pulse, sel 0->1
    @(negedge clk); btn_in = 1'b1; push(K_PULSE, cyc + LAT, 1'b1, 1'b1);
    wait_cyc(100);
    check1("hold_sel", sel, 1'b1);
    check1("hold_level", btn_level, 1'b1);
    @(negedge clk); btn_in = 1'b0; push(K_FALL, cyc + LAT, 1'b1, 1'b0);
    wait_cyc(10);

    // Four-cycle glitch: terminal count and mismatch coincide, abort wins
    @(negedge clk); btn_in = 1'b1;
    wait_cyc(4);
    btn_in = 1'b0;
    wait_cyc(15);
    check1("bounce_sel", sel, 1'b1);
    check1("bounce_level", btn_level, 1'b0);

    // Second press: sel 1->0
    @(negedge clk); btn_in = 1'b1; push(K_PULSE, cyc + LAT, 1'b0, 1'b1);
    wait_cyc(12);

    // Release bounce while pressed
    @(negedge clk); btn_in = 1'b0;
    wait_cyc(2);
    btn_in = 1'b1;
    wait_cyc(15);
    check1("relbounce_level", btn_level, 1'b1);
    check1("relbounce_sel", sel, 1'b0);
    @(negedge clk); btn_in = 1'b0; push(K_FALL, cyc + LAT, 1'b0, 1'b0);
    wait_cyc(12);

    // Reset in the middle of PRESS_WAIT
    begin
      int n;
      @(negedge clk); btn_in = 1'b1; n = cyc;
      while (cyc < n + 5) @(posedge clk);
      #2 resetn = 1'b0;
      #1 check3("reset_in_wait", {sel, press_pulse, btn_level}, 3'b000);
    end
    wait_cyc(3);
    resetn = 1'b1; push(K_PULSE, cyc + LAT, 1'b1, 1'b1);
    wait_cyc(12);
    check1("post_reset_sel", sel, 1'b1);

    // Reset while PRESSED drops outputs asynchronously
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check3("reset_in_pressed", {sel, press_pulse, btn_level}, 3'b000);
    wait_cyc(3);
    resetn = 1'b1; push(K_PULSE, cyc + LAT, 1'b1, 1'b1);
    wait_cyc(12);
    @(negedge clk); btn_in = 1'b0; push(K_FALL, cyc + LAT, 1'b1, 1'b0);
    wait_cyc(12);
    check1("final_sel", sel, 1'b1);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events still pending, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
